data_memory: RTL and testbench

Data Memory of the 8-bit CPU datapath: 256 × 8-bit storage on the receiving end of the data-select mux (literal or regB). The mux output feeds `wdata`. The block executes one memory operation per request: load, store, push or pop. It keeps the stack pointer internally and returns read data one cycle later with a valid strobe. Under a build option it clears the whole array after reset through a small state machine.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_if.sv | 16 +
 rtl/dmem_array.sv | 25 ++
 rtl/data_memory.sv | 79 +++++++
 tb/tb_data_memory.sv | 136 +++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared op codes, sizes and FSM states for data_memory
package dmem_pkg;
  localparam int DMEM_DEPTH = 256;
  localparam logic [7:0] DMEM_SP_INIT = 8'hFF;
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_t;
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between the CPU datapath and data_memory
interface dmem_if;
  import dmem_pkg::*;
  logic       req;
  op_t        op;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic [7:0] rdata;
  logic       rvalid;
  logic [7:0] sp;
  logic       ovf;
  logic       unf;
  modport master (output req, op, addr, wdata, input ready, rdata, rvalid, sp, ovf, unf);
  modport slave (input req, op, addr, wdata, output ready, rdata, rvalid, sp, ovf, unf);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: 256x8 storage with one synchronous write port and one registered read port
module dmem_array
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [7:0] raddr,
  input  logic       rclr,
  output logic [7:0] rdata
);
  logic [7:0] mem [DMEM_DEPTH];
  // write completes on the accepting edge, so a read on the next cycle sees it
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // read register; rclr forces the underflow-pop result to zero
  always_ff @(posedge clk) begin
    if (reset || rclr) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_memory.sv
// data_memory: 256x8 data memory with load/store/push/pop; DMEM_CLEAR_ON_RESET_EN zero-fills after reset
module data_memory
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  dmem_if.slave bus
);
  logic       ready, clearing, acc, we, re, rclr, rvalid, ovf, unf;
  logic [7:0] clr_addr, waddr, wd, raddr, sp, sp_nxt;
`ifdef DMEM_CLEAR_ON_RESET_EN
  state_t     state, state_nxt;
  logic [7:0] cnt;
  // state register and clear address counter; reset always restarts at address 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) cnt <= cnt + 8'd1;
    end
  end
  // leave CLEAR right after writing the last word
  always_comb begin
    state_nxt = state;
    state_nxt = (state == ST_CLEAR && cnt == 8'hFF) ? ST_IDLE : state;
  end
  assign ready    = state == ST_IDLE;
  assign clearing = state == ST_CLEAR && !reset;
  assign clr_addr = cnt;
`else
  assign ready    = 1'b1;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif
  assign acc = bus.req && ready && !reset;
  // array port steering and next stack pointer
  always_comb begin
    we     = clearing || (acc && (bus.op == OP_STORE || (bus.op == OP_PUSH && sp != 8'h00)));
    waddr  = clearing ? clr_addr : (bus.op == OP_STORE ? bus.addr : sp);
    wd     = clearing ? 8'h00 : bus.wdata;
    re     = acc && (bus.op == OP_LOAD || (bus.op == OP_POP && sp != 8'hFF));
    raddr  = bus.op == OP_LOAD ? bus.addr : sp + 8'd1;
    rclr   = acc && bus.op == OP_POP && sp == 8'hFF;
    sp_nxt = (acc && bus.op == OP_PUSH && sp != 8'h00) ? sp - 8'd1 :
             (acc && bus.op == OP_POP && sp != 8'hFF) ? sp + 8'd1 : sp;
  end
  // stack pointer, sticky flags and the read strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      sp     <= DMEM_SP_INIT;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      rvalid <= 1'b0;
    end else begin
      sp     <= sp_nxt;
      ovf    <= ovf || (acc && bus.op == OP_PUSH && sp == 8'h00);
      unf    <= unf || rclr;
      rvalid <= acc && (bus.op == OP_LOAD || bus.op == OP_POP);
    end
  end
  dmem_array u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wd),
    .re    (re),
    .raddr (raddr),
    .rclr  (rclr),
    .rdata (bus.rdata)
  );
  assign bus.ready  = ready;
  assign bus.rvalid = rvalid;
  assign bus.sp     = sp;
  assign bus.ovf    = ovf;
  assign bus.unf    = unf;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized check of data_memory against a behavioural model (DMEM_CLEAR_ON_RESET_EN selects clear tests)
module tb_data_memory;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dmem_if bus();
  data_memory dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [7:0] m [256];
  int sp_m = 255;
  bit ovf_m, unf_m;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_op(op_t o, logic [7:0] a, logic [7:0] d);
    bit exp_v;
    logic [7:0] exp_d;
    bus.req = 1'b1;
    bus.op = o;
    bus.addr = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    exp_v = (o == OP_LOAD) || (o == OP_POP);
    exp_d = 8'h00;
    if (o == OP_LOAD) exp_d = m[a];
    if (o == OP_STORE) m[a] = d;
    if (o == OP_PUSH) begin
      if (sp_m == 0) ovf_m = 1'b1;
      else begin
        m[sp_m] = d;
        sp_m = sp_m - 1;
      end
    end
    if (o == OP_POP) begin
      if (sp_m == 255) unf_m = 1'b1;
      else begin
        sp_m = sp_m + 1;
        exp_d = m[sp_m];
      end
    end
    chk($sformatf("rvalid op%0d", o), bus.rvalid, exp_v);
    if (exp_v) chk($sformatf("rdata op%0d a%0h", o, a), bus.rdata, exp_d);
    chk("sp", bus.sp, sp_m);
    chk("ovf", bus.ovf, ovf_m);
    chk("unf", bus.unf, unf_m);
    if (bus.rvalid) pulses++;
  endtask
  task automatic do_reset(bit poke);
    int n;
    reset = 1'b1;
    @(posedge clk);
    #1;
    sp_m = 255;
    ovf_m = 1'b0;
    unf_m = 1'b0;
    chk("rst rvalid", bus.rvalid, 0);
    chk("rst rdata", bus.rdata, 0);
    chk("rst sp", bus.sp, 8'hFF);
    chk("rst ovf", bus.ovf, 0);
    chk("rst unf", bus.unf, 0);
    reset = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    chk("rst ready", bus.ready, 0);
    n = 0;
    while (!bus.ready && n < 400) begin
      bus.req = poke && n == 10;
      bus.op = OP_STORE;
      bus.addr = 8'h05;
      bus.wdata = 8'hFF;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      n++;
    end
    chk("ready latency", n, 256);
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
`else
    n = poke;
    chk("rst ready", bus.ready, 1);
`endif
  endtask
  initial begin
    bus.req = 1'b0;
    bus.op = OP_LOAD;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
`ifdef DMEM_CLEAR_ON_RESET_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid clear ready", bus.ready, 0);
    do_reset(1'b0);
    do_op(OP_LOAD, 8'h80, 8'h00);
    do_reset(1'b1);
    do_op(OP_LOAD, 8'h05, 8'h00);
`endif
    for (int i = 0; i < 256; i++) do_op(OP_STORE, 8'(i), 8'($urandom));
    do_op(OP_STORE, 8'h10, 8'hA5);
    do_op(OP_LOAD, 8'h10, 8'h00);
    @(posedge clk);
    #1;
    chk("rvalid single pulse", bus.rvalid, 0);
    do_op(OP_PUSH, 8'h00, 8'h11);
    do_op(OP_PUSH, 8'h00, 8'h22);
    do_op(OP_POP, 8'h00, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00);
    do_op(OP_LOAD, 8'h10, 8'h00);
    do_op(OP_POP, 8'h00, 8'h00);
    for (int i = 0; i < 255; i++) do_op(OP_PUSH, 8'h00, 8'($urandom));
    do_op(OP_PUSH, 8'h00, 8'h5A);
    do_op(OP_LOAD, 8'h00, 8'h00);
    do_op(OP_LOAD, 8'h10, 8'h00);
    do_reset(1'b0);
    repeat (300) do_op(op_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    pulses = 0;
    for (int i = 0; i < 20; i++) do_op(i % 2 == 0 ? OP_LOAD : OP_STORE, 8'($urandom_range(0, 7)), 8'($urandom));
    chk("alt pulses", pulses, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
